// File: rtl/dllp_tx_arbiter.sv
// DLLP/TLP transmit arbiter: grants whole packets to Ack/Nak, UpdateFC or TLP sources (ack > fc > tlp).
// Define DLLP_TX_STARVE_GUARD_EN to build the aging counters that force starved fc/tlp sources through.

package pcie_dl_pkg;
    typedef enum logic [1:0] {
        DL_INACTIVE = 2'd0,
        DL_FEATURE  = 2'd1,
        DL_INIT     = 2'd2,
        DL_ACTIVE   = 2'd3
    } pcie_dl_status_e;
endpackage

module dllp_tx_arbiter
    import pcie_dl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  pcie_dl_status_e       link_status_i,
    input  logic                  phy_link_up_i,

    input  logic [DATA_WIDTH-1:0] s_ack_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_ack_axis_tkeep,
    input  logic                  s_ack_axis_tvalid,
    input  logic                  s_ack_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_ack_axis_tuser,
    output logic                  s_ack_axis_tready,

    input  logic [DATA_WIDTH-1:0] s_fc_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_fc_axis_tkeep,
    input  logic                  s_fc_axis_tvalid,
    input  logic                  s_fc_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_fc_axis_tuser,
    output logic                  s_fc_axis_tready,

    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic [2:0]            grant_o,
    output logic                  starve_force_o
);

    localparam int NSRC    = 3;
    localparam int SRC_ACK = 0;
    localparam int SRC_FC  = 1;
    localparam int SRC_TLP = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ACK = 2'd1,
        GNT_FC  = 2'd2,
        GNT_TLP = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] src_tdata [NSRC];
    logic [KEEP_WIDTH-1:0] src_tkeep [NSRC];
    logic [USER_WIDTH-1:0] src_tuser [NSRC];
    logic [NSRC-1:0]       src_tvalid;
    logic [NSRC-1:0]       src_tlast;
    logic [NSRC-1:0]       src_tready;

    logic [NSRC-1:0]       req;
    logic [NSRC-1:0]       base_win;
    logic [NSRC-1:0]       win;
    logic [NSRC-1:0]       grant;
    logic                  force_pick;
    logic                  decide;
    logic                  pkt_done;

    // Gather the three source ports into indexable arrays.
    assign src_tdata[SRC_ACK] = s_ack_axis_tdata;
    assign src_tdata[SRC_FC]  = s_fc_axis_tdata;
    assign src_tdata[SRC_TLP] = s_tlp_axis_tdata;
    assign src_tkeep[SRC_ACK] = s_ack_axis_tkeep;
    assign src_tkeep[SRC_FC]  = s_fc_axis_tkeep;
    assign src_tkeep[SRC_TLP] = s_tlp_axis_tkeep;
    assign src_tuser[SRC_ACK] = s_ack_axis_tuser;
    assign src_tuser[SRC_FC]  = s_fc_axis_tuser;
    assign src_tuser[SRC_TLP] = s_tlp_axis_tuser;
    assign src_tvalid         = {s_tlp_axis_tvalid, s_fc_axis_tvalid, s_ack_axis_tvalid};
    assign src_tlast          = {s_tlp_axis_tlast, s_fc_axis_tlast, s_ack_axis_tlast};

    assign s_ack_axis_tready  = src_tready[SRC_ACK];
    assign s_fc_axis_tready   = src_tready[SRC_FC];
    assign s_tlp_axis_tready  = src_tready[SRC_TLP];

    // Link gating is applied only here, at grant time; an in-flight packet always completes.
    assign req[SRC_ACK] = src_tvalid[SRC_ACK] & phy_link_up_i;
    assign req[SRC_FC]  = src_tvalid[SRC_FC]  & phy_link_up_i;
    assign req[SRC_TLP] = src_tvalid[SRC_TLP] & (link_status_i == DL_ACTIVE);

    always_comb begin
        base_win = '0;
        if (req[SRC_ACK]) begin
            base_win[SRC_ACK] = 1'b1;
        end else if (req[SRC_FC]) begin
            base_win[SRC_FC] = 1'b1;
        end else if (req[SRC_TLP]) begin
            base_win[SRC_TLP] = 1'b1;
        end
    end

    assign decide = (state_q == IDLE) && (|win);

`ifdef DLLP_TX_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] fc_wait_q, fc_wait_d;
    logic [7:0] tlp_wait_q, tlp_wait_d;
    logic       fc_force;
    logic       tlp_force;

    function automatic logic [7:0] age_step(input logic [7:0] cnt, input logic eligible,
                                            input logic won);
        logic [7:0] nxt;
        nxt = cnt;
        if (won) begin
            nxt = 8'd0;
        end else if (eligible && (cnt < LIMIT)) begin
            nxt = cnt + 8'd1;
        end
        return nxt;
    endfunction

    // FC starvation is resolved before TLP starvation.
    assign fc_force  = req[SRC_FC] && (fc_wait_q == LIMIT);
    assign tlp_force = !fc_force && req[SRC_TLP] && (tlp_wait_q == LIMIT);

    always_comb begin
        win        = base_win;
        force_pick = 1'b0;
        if (fc_force) begin
            win        = '0;
            win[SRC_FC] = 1'b1;
            force_pick = 1'b1;
        end else if (tlp_force) begin
            win         = '0;
            win[SRC_TLP] = 1'b1;
            force_pick  = 1'b1;
        end
    end

    always_comb begin
        fc_wait_d  = fc_wait_q;
        tlp_wait_d = tlp_wait_q;
        if (decide) begin
            fc_wait_d  = age_step(fc_wait_q, req[SRC_FC], win[SRC_FC]);
            tlp_wait_d = age_step(tlp_wait_q, req[SRC_TLP], win[SRC_TLP]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fc_wait_q  <= 8'd0;
            tlp_wait_q <= 8'd0;
        end else begin
            fc_wait_q  <= fc_wait_d;
            tlp_wait_q <= tlp_wait_d;
        end
    end
`else
    assign win        = base_win;
    assign force_pick = 1'b0;
`endif

    assign starve_force_o = decide & force_pick;

    always_comb begin
        grant = '0;
        case (state_q)
            GNT_ACK: grant[SRC_ACK] = 1'b1;
            GNT_FC:  grant[SRC_FC]  = 1'b1;
            GNT_TLP: grant[SRC_TLP] = 1'b1;
            default: grant = '0;
        endcase
    end

    assign grant_o  = grant;
    assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (win[SRC_ACK]) begin
                    state_d = GNT_ACK;
                end else if (win[SRC_FC]) begin
                    state_d = GNT_FC;
                end else if (win[SRC_TLP]) begin
                    state_d = GNT_TLP;
                end
            end
            default: begin
                if (pkt_done) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_ready
            assign src_tready[gi] = grant[gi] & m_axis_tready;
        end
    endgenerate

    // Pure combinational pass-through of the granted source; class flags overwrite tuser[1:0].
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                m_axis_tdata  = src_tdata[i];
                m_axis_tkeep  = src_tkeep[i];
                m_axis_tvalid = src_tvalid[i];
                m_axis_tlast  = src_tlast[i];
                m_axis_tuser  = src_tuser[i];
            end
        end
        if (grant[SRC_TLP]) begin
            m_axis_tuser[1:0] = 2'b10;
        end else if (|grant) begin
            m_axis_tuser[1:0] = 2'b01;
        end
    end

endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Directed bench for dllp_tx_arbiter: scripted packet sources, per-beat log and hand-derived expectations.
// Expectations for the aging test follow DLLP_TX_STARVE_GUARD_EN.

module tb_dllp_tx_arbiter;
    import pcie_dl_pkg::*;

    logic            clk;
    logic            rst_n_i;
    pcie_dl_status_e link_status_i;
    logic            phy_link_up_i;

    logic [31:0] s_ack_axis_tdata, s_fc_axis_tdata, s_tlp_axis_tdata;
    logic [3:0]  s_ack_axis_tkeep, s_fc_axis_tkeep, s_tlp_axis_tkeep;
    logic        s_ack_axis_tvalid, s_fc_axis_tvalid, s_tlp_axis_tvalid;
    logic        s_ack_axis_tlast, s_fc_axis_tlast, s_tlp_axis_tlast;
    logic [3:0]  s_ack_axis_tuser, s_fc_axis_tuser, s_tlp_axis_tuser;
    logic        s_ack_axis_tready, s_fc_axis_tready, s_tlp_axis_tready;

    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tuser;
    logic        m_axis_tready;
    logic [2:0]  grant_o;
    logic        starve_force_o;

    dllp_tx_arbiter #(
        .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .link_status_i(link_status_i), .phy_link_up_i(phy_link_up_i),
        .s_ack_axis_tdata(s_ack_axis_tdata), .s_ack_axis_tkeep(s_ack_axis_tkeep),
        .s_ack_axis_tvalid(s_ack_axis_tvalid), .s_ack_axis_tlast(s_ack_axis_tlast),
        .s_ack_axis_tuser(s_ack_axis_tuser), .s_ack_axis_tready(s_ack_axis_tready),
        .s_fc_axis_tdata(s_fc_axis_tdata), .s_fc_axis_tkeep(s_fc_axis_tkeep),
        .s_fc_axis_tvalid(s_fc_axis_tvalid), .s_fc_axis_tlast(s_fc_axis_tlast),
        .s_fc_axis_tuser(s_fc_axis_tuser), .s_fc_axis_tready(s_fc_axis_tready),
        .s_tlp_axis_tdata(s_tlp_axis_tdata), .s_tlp_axis_tkeep(s_tlp_axis_tkeep),
        .s_tlp_axis_tvalid(s_tlp_axis_tvalid), .s_tlp_axis_tlast(s_tlp_axis_tlast),
        .s_tlp_axis_tuser(s_tlp_axis_tuser), .s_tlp_axis_tready(s_tlp_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant_o(grant_o), .starve_force_o(starve_force_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Source model state, index 0=ack, 1=fc, 2=tlp.
    int rem  [3];
    int bidx [3];
    int pid  [3];
    bit ack_auto;

    int obs_src [$];
    int obs_beat[$];
    int obs_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] beat_data(input int s);
        return {8'(s + 1), 8'(pid[s]), 16'(bidx[s])};
    endfunction

    task automatic apply();
        s_ack_axis_tvalid = (rem[0] > 0);
        s_ack_axis_tlast  = (rem[0] == 1);
        s_ack_axis_tdata  = beat_data(0);
        s_ack_axis_tkeep  = (rem[0] == 1) ? 4'h7 : 4'hF;
        s_ack_axis_tuser  = 4'b1010;
        s_fc_axis_tvalid  = (rem[1] > 0);
        s_fc_axis_tlast   = (rem[1] == 1);
        s_fc_axis_tdata   = beat_data(1);
        s_fc_axis_tkeep   = (rem[1] == 1) ? 4'h7 : 4'hF;
        s_fc_axis_tuser   = 4'b1010;
        s_tlp_axis_tvalid = (rem[2] > 0);
        s_tlp_axis_tlast  = (rem[2] == 1);
        s_tlp_axis_tdata  = beat_data(2);
        s_tlp_axis_tkeep  = (rem[2] == 1) ? 4'h7 : 4'hF;
        s_tlp_axis_tuser  = 4'b0101;
    endtask

    task automatic start_pkt(input int s, input int len);
        rem[s]  = len;
        bidx[s] = 0;
        pid[s]  = pid[s] + 1;
    endtask

    task automatic load(input int s, input int len);
        start_pkt(s, len);
        apply();
        #1;
    endtask

    task automatic log_beat();
        int src;
        src = int'(m_axis_tdata[31:24]) - 1;
        obs_src.push_back(src);
        obs_beat.push_back(int'(m_axis_tdata[15:0]));
        obs_cyc.push_back(cyc);
        $display("beat cyc=%0d src=%0d pid=%0d beat=%0d last=%0b tuser=%0h grant=%03b",
                 cyc, src, m_axis_tdata[23:16], m_axis_tdata[15:0], m_axis_tlast, m_axis_tuser, grant_o);
        chk("beat_tuser", 32'(m_axis_tuser), (src == 2) ? 32'h6 : 32'h9);
        chk("beat_tkeep", 32'(m_axis_tkeep), m_axis_tlast ? 32'h7 : 32'hF);
        chk("beat_grant", 32'(grant_o), 32'(1 << src));
    endtask

    // Log the handshake of the current cycle, cross the edge, then advance the sources.
    task automatic step();
        logic [2:0] hs;
        #1;
        hs = {s_tlp_axis_tvalid & s_tlp_axis_tready,
              s_fc_axis_tvalid & s_fc_axis_tready,
              s_ack_axis_tvalid & s_ack_axis_tready};
        if (m_axis_tvalid && m_axis_tready) log_beat();
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < 3; s++) begin
            if (hs[s]) begin
                bidx[s]++;
                rem[s]--;
                if (s == 0 && ack_auto && rem[0] == 0) start_pkt(0, 1);
            end
        end
        apply();
        #1;
    endtask

    task automatic clear_log();
        obs_src.delete();
        obs_beat.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n_i  = 1'b0;
        ack_auto = 1'b0;
        for (int s = 0; s < 3; s++) rem[s] = 0;
        apply();
        step();
        step();
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'h0);
        chk({tag, "_grant"}, 32'(grant_o), 32'h0);
        chk({tag, "_treadys"}, 32'({s_tlp_axis_tready, s_fc_axis_tready, s_ack_axis_tready}), 32'h0);
        chk({tag, "_starve"}, 32'(starve_force_o), 32'h0);
    endtask

    initial begin
        int c0;
        int n_tlp;
        int exp2_src [6] = '{0, 0, 1, 1, 2, 2};
        int exp2_off [6] = '{1, 2, 4, 5, 7, 8};
        int exp5_off [7] = '{1, 3, 5, 7, 9, 11, 13};

        rst_n_i       = 1'b0;
        link_status_i = DL_ACTIVE;
        phy_link_up_i = 1'b1;
        m_axis_tready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            rem[s] = 0; bidx[s] = 0; pid[s] = 0;
        end
        ack_auto = 1'b0;
        apply();
        do_reset();
        chk_idle_outputs("rst");

        // Single 4-beat TLP: valid in cycles c0+1..c0+4, then an idle cycle.
        clear_log();
        c0 = cyc;
        load(2, 4);
        chk("t1_c0_tvalid", 32'(m_axis_tvalid), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t1_tvalid", 32'(m_axis_tvalid), (k <= 4) ? 32'h1 : 32'h0);
            chk("t1_grant", 32'(grant_o), (k <= 4) ? 32'h4 : 32'h0);
        end
        step();
        chk("t1_count", obs_src.size(), 4);
        for (int i = 0; i < obs_src.size() && i < 4; i++) begin
            chk("t1_beat", obs_beat[i], i);
            chk("t1_cyc", obs_cyc[i] - c0, i + 1);
        end

        // All three valid together: ack, fc, tlp with one idle cycle between packets.
        clear_log();
        c0 = cyc;
        start_pkt(0, 2);
        start_pkt(1, 2);
        load(2, 2);
        for (int k = 0; k < 10; k++) step();
        chk("t2_count", obs_src.size(), 6);
        for (int i = 0; i < obs_src.size() && i < 6; i++) begin
            chk("t2_src", obs_src[i], exp2_src[i]);
            chk("t2_cyc", obs_cyc[i] - c0, exp2_off[i]);
            chk("t2_beat", obs_beat[i], i % 2);
        end

        // Link not active: only FC goes; TLP follows the cycle after DL_ACTIVE is seen in IDLE.
        clear_log();
        link_status_i = DL_INIT;
        c0 = cyc;
        start_pkt(1, 2);
        load(2, 2);
        for (int k = 0; k < 5; k++) step();
        chk("t3_gated_grant", 32'(grant_o), 32'h0);
        chk("t3_gated_tready", 32'(s_tlp_axis_tready), 32'h0);
        link_status_i = DL_ACTIVE;
        #1;
        step();
        chk("t3_tlp_grant", 32'(grant_o), 32'h4);
        for (int k = 0; k < 4; k++) step();
        chk("t3_count", obs_src.size(), 4);
        if (obs_src.size() == 4) begin
            chk("t3_src0", obs_src[0], 1);
            chk("t3_cyc0", obs_cyc[0] - c0, 1);
            chk("t3_src2", obs_src[2], 2);
            chk("t3_cyc2", obs_cyc[2] - c0, 6);
        end

        // Continuous acks versus one pending TLP.
        do_reset();
        clear_log();
        c0 = cyc;
        ack_auto = 1'b1;
        start_pkt(0, 1);
        load(2, 1);
        for (int k = 0; k < 20; k++) begin
`ifdef DLLP_TX_STARVE_GUARD_EN
            chk("t4_starve", 32'(starve_force_o), (k == 6) ? 32'h1 : 32'h0);
`else
            chk("t4_starve", 32'(starve_force_o), 32'h0);
`endif
            step();
        end
        n_tlp = 0;
        foreach (obs_src[i]) if (obs_src[i] == 2) n_tlp++;
`ifdef DLLP_TX_STARVE_GUARD_EN
        chk("t4_tlp_beats", n_tlp, 1);
        if (obs_src.size() > 4) begin
            chk("t4_forced_src", obs_src[3], 2);
            chk("t4_forced_cyc", obs_cyc[3] - c0, 7);
            chk("t4_resume_src", obs_src[4], 0);
        end else begin
            chk("t4_log_size", obs_src.size(), 5);
        end
`else
        chk("t4_tlp_beats", n_tlp, 0);
        chk("t4_ack_beats", obs_src.size(), 10);
`endif
        ack_auto = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Backpressure on a 6-beat TLP with an ack arriving mid-packet.
        clear_log();
        c0 = cyc;
        m_axis_tready = 1'b0;
        load(2, 6);
        for (int k = 0; k < 16; k++) begin
            m_axis_tready = k[0];
            if (k == 3) load(0, 1);
            if (k == 4) begin
                #1;
                chk("t5_ack_blocked", 32'(s_ack_axis_tready), 32'h0);
                chk("t5_grant_tlp", 32'(grant_o), 32'h4);
            end
            step();
        end
        m_axis_tready = 1'b1;
        chk("t5_count", obs_src.size(), 7);
        for (int i = 0; i < obs_src.size() && i < 7; i++) begin
            chk("t5_src", obs_src[i], (i < 6) ? 2 : 0);
            chk("t5_beat", obs_beat[i], (i < 6) ? i : 0);
            chk("t5_cyc", obs_cyc[i] - c0, exp5_off[i]);
        end

        // Reset at beat 2 of a 5-beat TLP; afterwards the pending ack wins.
        clear_log();
        load(2, 5);
        step();
        step();
        step();
        chk("t6_mid_grant", 32'(grant_o), 32'h4);
        rst_n_i = 1'b0;
        load(0, 1);
        step();
        chk_idle_outputs("t6_rst");
        rst_n_i = 1'b1;
        load(2, 1);
        step();
        chk("t6_ack_first", 32'(grant_o), 32'h1);
        for (int k = 0; k < 4; k++) step();
        chk("t6_tlp_after", obs_src.size() > 0 ? obs_src[obs_src.size() - 1] : -1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dllp_tx_arbiter.md
# dllp_tx_arbiter

Packet-level scheduler that shares the single datalink-to-physical transmit AXI-Stream between three requesters: the Ack/Nak DLLP generator, the UpdateFC DLLP generator, and the TLP transmit path. It sits between those generators and the physical layer TX interface. It grants one whole packet at a time, applies fixed priority with optional anti-starvation aging, gates TLPs on link state, and tags each beat's tuser with the packet class.

## Interface
- DATA_WIDTH, 32, stream data width
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 4, tuser width (≥2)
- STARVE_LIMIT, 8, packet grants a waiting lower-priority source may lose before being forced (1..255)

- clk_i  in  1  clock
- rst_n_i  in  1  reset; synchronous, active-low. One clock domain only.
- link_status_i  in  pcie_dl_status_e  datalink state; TLPs are granted only when DL_ACTIVE
- phy_link_up_i  in  1  DLLPs are granted only when high
- s_ack_axis_{tdata,tkeep,tvalid,tlast,tuser,tready}  in/out  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH/1  Ack/Nak DLLP source
- s_fc_axis_{…}  same widths  UpdateFC DLLP source
- s_tlp_axis_{…}  same widths  TLP source
- m_axis_{tdata,tkeep,tvalid,tlast,tuser,tready}  out/in  same widths  to the physical layer
- grant_o  out  3  one-hot current grant {tlp,fc,ack}; 0 in IDLE
- starve_force_o  out  1  pulses for one cycle when an aging override picks the winner

## Operation
- FSM states: IDLE, GNT_ACK, GNT_FC, GNT_TLP.
- Eligibility in IDLE: ack_req = s_ack tvalid & phy_link_up_i; fc_req = s_fc tvalid & phy_link_up_i; tlp_req = s_tlp tvalid & (link_status_i==DL_ACTIVE).
- Base priority: ack > fc > tlp. Override (when the configuration macro is defined): if fc_wait_cnt==STARVE_LIMIT and fc_req, FC wins. Otherwise, if tlp_wait_cnt==STARVE_LIMIT and tlp_req, TLP wins. The FC override is checked before the TLP override.
- IDLE → GNT_x on a registered winner. With no eligible request, the FSM stays in IDLE.
- GNT_x: m_axis tdata/tkeep/tvalid/tlast pass combinationally from source x. Source x tready equals m_axis_tready. Every other source's tready is 0.
- tuser on m_axis equals the source tuser with bit 0 (IsDllp) and bit 1 (IsTlp) overwritten: ack/fc → bit0=1, bit1=0; tlp → bit0=0, bit1=1.
- GNT_x → IDLE on a beat with tvalid & tready & tlast.
- A packet is never preempted or truncated. Loss of link or phy_link_up_i mid-packet does not abort it; gating applies only at grant time.
- Aging counters fc_wait_cnt and tlp_wait_cnt are 8-bit, saturating at STARVE_LIMIT.
  - Each increments at a grant to another source while its own request is eligible.
  - Each clears when its own source is granted.
  - A counter holds while its own request is absent.

## Timing
- Reset (rst_n_i low at a clock edge): state=IDLE, counters=0, grant_o=0, starve_force_o=0, m_axis_tvalid=0, all s_*_tready=0. Data outputs are don't-care while tvalid=0. This applies mid-packet too; the partially sent packet is abandoned.
- Arbitration latency: tvalid on an eligible source in cycle N gives the first m_axis_tvalid in cycle N+1.
- Packet gap: one IDLE cycle after each tlast beat. Maximum throughput is L/(L+1) for L-beat packets.
- Sampling rule: requests arriving in the same cycle are resolved by priority in that IDLE cycle. A request arriving during GNT_x waits for the next IDLE.
- starve_force_o asserts in the IDLE cycle whose registered decision was an override.
- Backpressure: m_axis_tready=0 holds the beat. Source tvalid/tdata must stay stable per AXIS rules; the arbiter adds no buffering.

## Configuration
- DLLP_TX_STARVE_GUARD_EN defined: aging counters and overrides are active, and starve_force_o is live.
- DLLP_TX_STARVE_GUARD_EN undefined: strict ack > fc > tlp priority. Counters are not built, starve_force_o is tied 0, and STARVE_LIMIT is ignored.

## Test plan
- Single 4-beat TLP, DL_ACTIVE, tready=1 → m_axis_tvalid from cycle N+1 to N+4, tuser[1:0]=2'b10, grant_o=3'b100, then IDLE for one cycle.
- ack, fc and tlp all valid in the same cycle, 2-beat DLLPs → order ack, fc, tlp. Each DLLP carries tuser[1:0]=2'b01, with one idle cycle between packets.
- link_status_i≠DL_ACTIVE with a TLP valid and an FC DLLP valid → only the FC DLLP is sent; the TLP is granted the cycle after DL_ACTIVE is sampled in IDLE.
- With guard enabled and STARVE_LIMIT=3: ack valid continuously, tlp valid continuously → after three ack grants, starve_force_o pulses and one TLP is sent, then acks resume. With guard disabled → no TLP is ever sent.
- m_axis_tready toggling 1/0 during a 6-beat TLP while an ack arrives mid-packet → TLP beats are delivered intact and in order, and the ack is granted only after the TLP tlast.
- rst_n_i low for one cycle at beat 2 of a 5-beat TLP → next cycle all outputs are at reset values. After release, a pending ack is granted first.
